// File: rtl/mem_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_port_arbiter: round-robin sharing of one physical-memory port between  |
// | the fetch cache (A) and the memory-stage cache (B).  Rev 1.0               |
// +----------------------------------------------------------------------------+
module mem_port_arbiter #(
  parameter int ADDR_W = 16,
  parameter int LINE_W = 128,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_read,
  input  logic              a_write,
  input  logic [ADDR_W-1:0] a_address,
  input  logic [LINE_W-1:0] a_wdata,
  output logic              a_resp,
  output logic [LINE_W-1:0] a_rdata,
  input  logic              b_read,
  input  logic              b_write,
  input  logic [ADDR_W-1:0] b_address,
  input  logic [LINE_W-1:0] b_wdata,
  output logic              b_resp,
  output logic [LINE_W-1:0] b_rdata,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic              pmem_resp,
  input  logic [LINE_W-1:0] pmem_rdata,
  output logic [CNT_W-1:0]  a_grants,
  output logic [CNT_W-1:0]  b_grants
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SERVE_A = 2'd1,
    S_SERVE_B = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] C_CNT_MAX = '1;

  state_t           state_q, state_d;
  logic             last_b_q, last_b_d;
  logic [CNT_W-1:0] a_grants_q, a_grants_d;
  logic [CNT_W-1:0] b_grants_q, b_grants_d;
  logic             w_req_a, w_req_b;

  assign w_req_a = a_read | a_write;
  assign w_req_b = b_read | b_write;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      last_b_q   <= 1'b0;
      a_grants_q <= '0;
      b_grants_q <= '0;
    end else begin
      state_q    <= state_d;
      last_b_q   <= last_b_d;
      a_grants_q <= a_grants_d;
      b_grants_q <= b_grants_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_b_d     = last_b_q;
    a_grants_d   = a_grants_q;
    b_grants_d   = b_grants_q;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    pmem_wdata   = '0;
    a_resp       = 1'b0;
    b_resp       = 1'b0;
    a_rdata      = '0;
    b_rdata      = '0;

    case (state_q)
      S_IDLE: begin
        // On a tie the port that did not win last time is granted.
        if (w_req_a && (!w_req_b || last_b_q)) begin
          state_d  = S_SERVE_A;
          last_b_d = 1'b0;
          if (a_grants_q != C_CNT_MAX) a_grants_d = a_grants_q + CNT_W'(1);
        end else if (w_req_b) begin
          state_d  = S_SERVE_B;
          last_b_d = 1'b1;
          if (b_grants_q != C_CNT_MAX) b_grants_d = b_grants_q + CNT_W'(1);
        end
      end

      S_SERVE_A: begin
        pmem_write   = a_write;
        pmem_read    = a_read & ~a_write;
        pmem_address = a_address;
        pmem_wdata   = a_wdata;
        if (!w_req_a) begin
          state_d = S_IDLE;
        end else if (pmem_resp) begin
          a_resp  = 1'b1;
          a_rdata = pmem_rdata;
          state_d = S_IDLE;
        end
      end

      S_SERVE_B: begin
        pmem_write   = b_write;
        pmem_read    = b_read & ~b_write;
        pmem_address = b_address;
        pmem_wdata   = b_wdata;
        if (!w_req_b) begin
          state_d = S_IDLE;
        end else if (pmem_resp) begin
          b_resp  = 1'b1;
          b_rdata = pmem_rdata;
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign a_grants = a_grants_q;
  assign b_grants = b_grants_q;

endmodule
`default_nettype wire
